// File: rtl/frost32_mem_arbiter.sv
// Frost32 external memory port arbiter.
// Shares one memory bus between instruction fetch (F) and load/store (D).
// Each transaction walks IDLE -> ISSUE -> WAIT -> DONE. D normally wins
// arbitration. After STARVE_LIMIT consecutive D grants with F pending,
// F is forced through.
module frost32_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_done,
    output logic [DATA_WIDTH-1:0] f_rdata,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic                  d_type,
    input  logic [1:0]            d_size,
    output logic                  d_done,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_type,
    output logic [1:0]            mem_size,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_wait
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);
    localparam logic [1:0] SIZE_32    = 2'd0;
    localparam logic [1:0] SIZE_BAD   = 2'd3;
    localparam logic       OWNER_F    = 1'b0;
    localparam logic       OWNER_D    = 1'b1;

    state_t                state_reg, state_next;
    logic                  owner_reg, owner_next;
    logic [3:0]            streak_reg, streak_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_WIDTH-1:0] mem_wdata_reg, mem_wdata_next;
    logic                  mem_type_reg, mem_type_next;
    logic [1:0]            mem_size_reg, mem_size_next;
    logic [DATA_WIDTH-1:0] f_rdata_reg, f_rdata_next;
    logic [DATA_WIDTH-1:0] d_rdata_reg, d_rdata_next;
    logic                  d_err_reg, d_err_next;
    logic                  d_valid;
    logic                  f_wins;

    // State and datapath registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= OWNER_F;
            streak_reg    <= 4'd0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_type_reg  <= 1'b0;
            mem_size_reg  <= SIZE_32;
            f_rdata_reg   <= '0;
            d_rdata_reg   <= '0;
            d_err_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            streak_reg    <= streak_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_type_reg  <= mem_type_next;
            mem_size_reg  <= mem_size_next;
            f_rdata_reg   <= f_rdata_next;
            d_rdata_reg   <= d_rdata_next;
            d_err_reg     <= d_err_next;
        end
    end

    // Arbitration, bus sequencing, read-data capture and starvation tracking.
    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        streak_next    = streak_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_type_next  = mem_type_reg;
        mem_size_next  = mem_size_reg;
        f_rdata_next   = f_rdata_reg;
        d_rdata_next   = d_rdata_reg;
        d_err_next     = 1'b0;
        // A D request still high during its own d_err cycle is the one just
        // rejected, not a new one.
        d_valid        = d_req && !d_err_reg;
        f_wins         = f_req && (!d_valid || (streak_reg == STREAK_MAX));

        case (state_reg)
            ST_IDLE: begin
                if (f_wins) begin
                    mem_addr_next  = f_addr;
                    mem_wdata_next = '0;
                    mem_type_next  = 1'b0;
                    mem_size_next  = SIZE_32;
                    owner_next     = OWNER_F;
                    streak_next    = 4'd0;
                    state_next     = ST_ISSUE;
                end else if (d_valid) begin
                    if (d_size == SIZE_BAD) begin
                        // Rejected without a bus cycle; streak untouched.
                        d_err_next = 1'b1;
                    end else begin
                        mem_addr_next  = d_addr;
                        mem_wdata_next = d_wdata;
                        mem_type_next  = d_type;
                        mem_size_next  = d_size;
                        owner_next     = OWNER_D;
                        state_next     = ST_ISSUE;
                        if (!f_req) begin
                            streak_next = 4'd0;
                        end else if (streak_reg != STREAK_MAX) begin
                            streak_next = streak_reg + 4'd1;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (!mem_wait) begin
                    if (owner_reg == OWNER_F) begin
                        f_rdata_next = mem_rdata;
                    end else if (!mem_type_reg) begin
                        d_rdata_next = mem_rdata;
                    end
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign mem_req   = (state_reg == ST_ISSUE);
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_type  = mem_type_reg;
    assign mem_size  = mem_size_reg;
    assign f_done    = (state_reg == ST_DONE) && (owner_reg == OWNER_F);
    assign d_done    = (state_reg == ST_DONE) && (owner_reg == OWNER_D);
    assign f_rdata   = f_rdata_reg;
    assign d_rdata   = d_rdata_reg;
    assign d_err     = d_err_reg;

endmodule
